// File: rtl/udp_srio_tx_sched_if.sv
// rtl/udp_srio_tx_sched_if.sv - per-channel source bundle and shared SRIO TX stream interfaces
interface udp_srio_src_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH*32-1:0] tdata;
    logic [NUM_CH-1:0]    tvalid;
    logic [NUM_CH-1:0]    tfirst;
    logic [NUM_CH*4-1:0]  tkeep;
    logic [NUM_CH-1:0]    tlast;
    logic [NUM_CH*16-1:0] length;
    logic [NUM_CH-1:0]    tready;

    modport master (
        output tdata, tvalid, tfirst, tkeep, tlast, length,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tfirst, tkeep, tlast, length,
        output tready
    );
endinterface

interface udp_srio_tx_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        thdr;
    logic        tready;

    modport master (
        output tdata, tvalid, tkeep, tlast, thdr,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tkeep, tlast, thdr,
        output tready
    );
endinterface

// File: rtl/udp_srio_tx_sched.sv
// rtl/udp_srio_tx_sched.sv - packet round-robin scheduler of UDP channels onto one SRIO TX stream
module udp_srio_tx_sched #(
    parameter int NUM_CH  = 2,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    udp_srio_src_if.slave   src,
    udp_srio_tx_if.master   tx,
    output logic [CH_W-1:0] grant_ch,
    output logic            busy,
    output logic            pkt_abort
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_ABORT,
        ST_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] grant_d;
    logic [15:0]     len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            abort_d;

    logic            req_found;
    logic [CH_W-1:0] req_ch;
    logic [15:0]     req_len;
    logic [CH_W:0]   scan_idx;

    logic [31:0]     g_data;
    logic [3:0]      g_keep;
    logic            g_valid;
    logic            g_last;
    logic [CH_W-1:0] next_ptr;

    // Round-robin scan starting at rr_ptr; only a tfirst beat counts as a request.
    always_comb begin
        req_found = 1'b0;
        req_ch    = '0;
        req_len   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
            if (scan_idx >= (CH_W+1)'(NUM_CH))
                scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
            for (int i = 0; i < NUM_CH; i++) begin
                if (!req_found && scan_idx == (CH_W+1)'(i) && src.tvalid[i] && src.tfirst[i]) begin
                    req_found = 1'b1;
                    req_ch    = CH_W'(i);
                    req_len   = src.length[16*i +: 16];
                end
            end
        end
    end

    always_comb begin
        g_data  = '0;
        g_keep  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_ch == CH_W'(i)) begin
                g_data  = src.tdata[32*i +: 32];
                g_keep  = src.tkeep[4*i +: 4];
                g_valid = src.tvalid[i];
                g_last  = src.tlast[i];
            end
        end
    end

    always_comb begin
        if (grant_ch == CH_W'(NUM_CH-1))
            next_ptr = '0;
        else
            next_ptr = grant_ch + 1'b1;
    end

    always_comb begin
        src.tready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_ch == CH_W'(i)) begin
                if (state_q == ST_DATA)
                    src.tready[i] = tx.tready;
                else if (state_q == ST_FLUSH)
                    src.tready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_ch;
        len_d     = len_q;
        cnt_d     = cnt_q;
        abort_d   = 1'b0;
        tx.tvalid = 1'b0;
        tx.tdata  = '0;
        tx.tkeep  = '0;
        tx.tlast  = 1'b0;
        tx.thdr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    grant_d = req_ch;
                    len_d   = req_len;
                    state_d = ST_HDR;
                end
            end

            ST_HDR: begin
                tx.tvalid = 1'b1;
                tx.thdr   = 1'b1;
                tx.tdata  = {{(8-CH_W){1'b0}}, grant_ch, 8'h00, len_q};
                tx.tkeep  = 4'hF;
                if (tx.tready) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                tx.tvalid = g_valid;
                tx.tdata  = g_data;
                tx.tkeep  = g_keep;
                tx.tlast  = g_last;
                // A present-but-backpressured beat keeps the watchdog cleared.
                if (g_valid) begin
                    cnt_d = '0;
                    if (tx.tready && g_last) begin
                        rr_ptr_d = next_ptr;
                        state_d  = ST_IDLE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
                    abort_d = 1'b1;
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_ABORT: begin
                tx.tvalid = 1'b1;
                tx.tlast  = 1'b1;
                if (tx.tready)
                    state_d = ST_FLUSH;
            end

            ST_FLUSH: begin
                if (g_valid && g_last) begin
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            grant_ch  <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            pkt_abort <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_ch  <= grant_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            pkt_abort <= abort_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udp_srio_tx_sched.sv
// tb/tb_udp_srio_tx_sched.sv - self-checking bench for udp_srio_tx_sched with scoreboard of expected TX beats
module tb_udp_srio_tx_sched;
    localparam int NUM_CH  = 2;
    localparam int CH_W    = 1;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic        hdr;
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        int          ch;
        int          nb;
        logic [15:0] len;
        logic [31:0] d [8];
        logic [3:0]  klast;
    } pkt_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH_W-1:0] grant_ch;
    logic            busy;
    logic            pkt_abort;

    udp_srio_src_if #(.NUM_CH(NUM_CH)) src();
    udp_srio_tx_if tx();

    udp_srio_tx_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (src),
        .tx        (tx),
        .grant_ch  (grant_ch),
        .busy      (busy),
        .pkt_abort (pkt_abort)
    );

    always #5 clk = ~clk;

    int    passed = 0;
    int    total  = 0;
    int    cyc    = 0;
    bit    rdy_rand = 1'b0;
    beat_t exp_q[$];
    int    abort_pulses = 0;
    int    abort_cyc = -1;
    int    ref_cyc0 = 0;
    int    ref_cyc1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        tx.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: pop expected beats on each handshake, check hold during stalls.
    beat_t cur_b, prev_b;
    bit    stalled = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            cur_b = {tx.thdr, tx.tlast, tx.tkeep, tx.tdata};
            if (stalled)
                check("stall_hold", {tx.tvalid, cur_b}, {1'b1, prev_b});
            if (tx.tvalid && tx.tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $error("FAIL unexpected_beat: got 0x%0h expected no beat", cur_b);
                end else begin
                    check("tx_beat", cur_b, exp_q.pop_front());
                end
            end
            stalled = tx.tvalid && !tx.tready;
            prev_b  = cur_b;
            if (pkt_abort) begin
                abort_pulses++;
                abort_cyc = cyc;
            end
        end
    end

    function automatic pkt_t make_pkt(input int ch, input int nb, input logic [15:0] len, input logic [3:0] klast);
        pkt_t p;
        p.ch = ch;
        p.nb = nb;
        p.len = len;
        p.klast = klast;
        for (int i = 0; i < 8; i++) p.d[i] = $urandom;
        return p;
    endfunction

    // Model: header = channel in bits 31:24, zero byte, length in 15:0; payload verbatim.
    task automatic expect_hdr(input pkt_t p);
        exp_q.push_back({1'b1, 1'b0, 4'hF, (32'(p.ch) << 24) | 32'(p.len)});
    endtask

    task automatic expect_pkt(input pkt_t p);
        expect_hdr(p);
        for (int i = 0; i < p.nb; i++)
            exp_q.push_back({1'b0, i == p.nb - 1, (i == p.nb - 1) ? p.klast : 4'hF, p.d[i]});
    endtask

    task automatic expect_abort(input pkt_t p, input int n_sent);
        expect_hdr(p);
        for (int i = 0; i < n_sent; i++)
            exp_q.push_back({1'b0, 1'b0, 4'hF, p.d[i]});
        exp_q.push_back({1'b0, 1'b1, 4'h0, 32'h0});
    endtask

    task automatic clear_src();
        src.tdata  = '0;
        src.tvalid = '0;
        src.tfirst = '0;
        src.tkeep  = '0;
        src.tlast  = '0;
        src.length = '0;
    endtask

    task automatic wait_acc(input int ch, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (src.tready[ch]) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) return;
        end
        total++;
        $error("FAIL accept_timeout ch%0d: got no tready expected tready within 2000 cycles", ch);
    endtask

    task automatic drive_pkt(input pkt_t p, input int stall_after, input int stall_len,
                             input bit gaps, output int ref_cyc);
        bit ok;
        ref_cyc = 0;
        for (int i = 0; i < p.nb; i++) begin
            if (i == stall_after || (gaps && i > 0 && $urandom_range(0, 3) == 0)) begin
                src.tvalid[p.ch] = 1'b0;
                repeat ((i == stall_after) ? stall_len : int'($urandom_range(1, 3))) @(posedge clk);
                #1;
            end
            src.tdata[32*p.ch +: 32]  = p.d[i];
            src.tkeep[4*p.ch +: 4]    = (i == p.nb - 1) ? p.klast : 4'hF;
            src.tlast[p.ch]           = (i == p.nb - 1);
            src.tfirst[p.ch]          = (i == 0);
            src.length[16*p.ch +: 16] = p.len;
            src.tvalid[p.ch]          = 1'b1;
            wait_acc(p.ch, ok);
            if (!ok) begin
                src.tvalid[p.ch] = 1'b0;
                return;
            end
            if (i == stall_after - 1) ref_cyc = cyc;
        end
        src.tvalid[p.ch] = 1'b0;
        src.tfirst[p.ch] = 1'b0;
        src.tlast[p.ch]  = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 3000 && (exp_q.size() != 0 || busy); n++) begin
            @(posedge clk);
            #1;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_src();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000 ns");
        $fatal(1);
    end

    initial begin
        pkt_t p0, p1, q0, q1;
        pkt_t a0 [6];
        pkt_t a1 [6];
        bit   ok;

        reset = 1'b1;
        clear_src();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(tx.tvalid), 64'd0);
        check("rst_tdata", 64'(tx.tdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant_ch), 64'd0);
        check("rst_abort", 64'(pkt_abort), 64'd0);
        check("rst_s_tready", 64'(src.tready), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single channel, fixed length, partial last word.
        p0 = make_pkt(0, 3, 16'h000B, 4'hE);
        expect_pkt(p0);
        drive_pkt(p0, -1, 0, 1'b0, ref_cyc0);
        drain("drain_single");

        // Both channels after reset, twice, with random backpressure.
        do_reset();
        rdy_rand = 1'b1;
        p0 = make_pkt(0, $urandom_range(1, 4), 16'($urandom), 4'hF);
        p1 = make_pkt(1, $urandom_range(1, 4), 16'($urandom), 4'h3);
        q0 = make_pkt(0, $urandom_range(1, 4), 16'($urandom), 4'h7);
        q1 = make_pkt(1, $urandom_range(1, 4), 16'($urandom), 4'h1);
        expect_pkt(p0); expect_pkt(p1); expect_pkt(q0); expect_pkt(q1);
        fork
            begin drive_pkt(p0, -1, 0, 1'b0, ref_cyc0); drive_pkt(q0, -1, 0, 1'b0, ref_cyc0); end
            begin drive_pkt(p1, -1, 0, 1'b0, ref_cyc1); drive_pkt(q1, -1, 0, 1'b0, ref_cyc1); end
        join
        drain("drain_rr_pair");

        // Randomized contention: with both always pending the grants must alternate.
        for (int i = 0; i < 6; i++) begin
            a0[i] = make_pkt(0, $urandom_range(1, 8), 16'($urandom), 4'($urandom_range(1, 15)));
            a1[i] = make_pkt(1, $urandom_range(1, 8), 16'($urandom), 4'($urandom_range(1, 15)));
            expect_pkt(a0[i]);
            expect_pkt(a1[i]);
        end
        fork
            begin for (int i = 0; i < 6; i++) drive_pkt(a0[i], -1, 0, 1'b1, ref_cyc0); end
            begin for (int i = 0; i < 6; i++) drive_pkt(a1[i], -1, 0, 1'b1, ref_cyc1); end
        join
        drain("drain_random");

        // Ch0 stalls past the watchdog; remainder flushed, then ch1 served.
        rdy_rand = 1'b0;
        abort_pulses = 0;
        p0 = make_pkt(0, 5, 16'h0013, 4'hF);
        p1 = make_pkt(1, 3, 16'h000A, 4'hC);
        expect_abort(p0, 2);
        expect_pkt(p1);
        fork
            drive_pkt(p0, 2, 20, 1'b0, ref_cyc0);
            drive_pkt(p1, -1, 0, 1'b0, ref_cyc1);
        join
        drain("drain_abort");
        check("abort_pulses", 64'(abort_pulses), 64'd1);
        check("abort_latency", 64'(abort_cyc - ref_cyc0), 64'(TIMEOUT));

        // Reset in the middle of a ch1 payload.
        p1 = make_pkt(1, 6, 16'h0017, 4'hF);
        exp_q.push_back({1'b1, 1'b0, 4'hF, (32'd1 << 24) | 32'h0017});
        exp_q.push_back({1'b0, 1'b0, 4'hF, p1.d[0]});
        src.tdata[63:32]  = p1.d[0];
        src.tkeep[7:4]    = 4'hF;
        src.tlast[1]      = 1'b0;
        src.tfirst[1]     = 1'b1;
        src.length[31:16] = p1.len;
        src.tvalid[1]     = 1'b1;
        wait_acc(1, ok);
        src.tdata[63:32]  = p1.d[1];
        src.tfirst[1]     = 1'b0;
        check("pre_reset_grant", 64'(grant_ch), 64'd1);
        reset = 1'b1;
        clear_src();
        @(posedge clk);
        #1;
        check("mid_rst_tvalid", 64'(tx.tvalid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_grant", 64'(grant_ch), 64'd0);
        check("mid_rst_out", 64'({tx.tdata, tx.tkeep, tx.tlast, tx.thdr, pkt_abort}), 64'd0);
        check("mid_rst_s_tready", 64'(src.tready), 64'd0);
        check("mid_rst_queue", 64'(exp_q.size()), 64'd0);
        reset = 1'b0;
        p0 = make_pkt(0, 2, 16'h0007, 4'hF);
        p1 = make_pkt(1, 2, 16'h0005, 4'h8);
        expect_pkt(p0);
        expect_pkt(p1);
        fork
            drive_pkt(p0, -1, 0, 1'b0, ref_cyc0);
            drive_pkt(p1, -1, 0, 1'b0, ref_cyc1);
        join
        drain("drain_post_reset");

        // One cycle short of the watchdog: packet must complete intact.
        abort_pulses = 0;
        p1 = make_pkt(1, 5, 16'h0013, 4'hF);
        expect_pkt(p1);
        drive_pkt(p1, 2, TIMEOUT - 1, 1'b0, ref_cyc1);
        drain("drain_near_timeout");
        check("near_timeout_no_abort", 64'(abort_pulses), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
